// File: rtl/rega_temporizador.sv
// Irrigation timing controller: one-second tick and display-scan prescalers plus the watering FSM
// that drives the remaining-seconds digit, state code, valve enables and tank-low alarm.
module rega_temporizador #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DUR_GOTEJ = 9,
  parameter int unsigned DUR_ASPER = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SOLO_SECO,
  input  logic       NIVEL_BAIXO,
  input  logic       MODO_ASPER,
  output logic       S,
  output logic [3:0] ContA,
  output logic [1:0] ContB,
  output logic       VALV_GOT,
  output logic       VALV_ASP,
  output logic       ALARME
);

  localparam int unsigned TickW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'((SCAN_DIV > 0) ? SCAN_DIV - 1 : 0);

  // Out-of-range durations are pulled into the single BCD digit range 1..9.
  localparam int unsigned DurGotC = (DUR_GOTEJ < 1) ? 1 : (DUR_GOTEJ > 9) ? 9 : DUR_GOTEJ;
  localparam int unsigned DurAspC = (DUR_ASPER < 1) ? 1 : (DUR_ASPER > 9) ? 9 : DUR_ASPER;
  localparam logic [3:0]  DurGot  = 4'(DurGotC);
  localparam logic [3:0]  DurAsp  = 4'(DurAspC);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGotej  = 2'b01,
    StAsper  = 2'b10,
    StAlarme = 2'b11
  } state_e;

  state_e           state_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [ScanW-1:0] scan_cnt_q;
  logic             tick;

  assign tick  = (tick_cnt_q == TickLast);
  assign ContB = state_q;

  // Free-running one-second prescaler; only RST restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  // Display scan strobe: toggles on every prescaler wrap, independent of the FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt_q <= '0;
      S          <= 1'b0;
    end else if (scan_cnt_q == ScanLast) begin
      scan_cnt_q <= '0;
      S          <= ~S;
    end else begin
      scan_cnt_q <= scan_cnt_q + ScanW'(1);
    end
  end

  // Watering FSM with registered outputs; tank-low overrides every other event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      ContA    <= 4'd0;
      VALV_GOT <= 1'b0;
      VALV_ASP <= 1'b0;
      ALARME   <= 1'b0;
    end else if (NIVEL_BAIXO) begin
      state_q  <= StAlarme;
      ContA    <= 4'd0;
      VALV_GOT <= 1'b0;
      VALV_ASP <= 1'b0;
      ALARME   <= 1'b1;
    end else begin
      case (state_q)
        StAlarme: begin
          state_q <= StIdle;
          ALARME  <= 1'b0;
        end
        StIdle: begin
          if (tick && SOLO_SECO) begin
            if (MODO_ASPER) begin
              state_q  <= StAsper;
              ContA    <= DurAsp;
              VALV_ASP <= 1'b1;
            end else begin
              state_q  <= StGotej;
              ContA    <= DurGot;
              VALV_GOT <= 1'b1;
            end
          end
        end
        StGotej, StAsper: begin
          if (tick) begin
            if (ContA > 4'd1) begin
              ContA <= ContA - 4'd1;
            end else begin
              // Last second elapsed (0 is handled the same way so the digit never wraps).
              state_q  <= StIdle;
              ContA    <= 4'd0;
              VALV_GOT <= 1'b0;
              VALV_ASP <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          ContA    <= 4'd0;
          VALV_GOT <= 1'b0;
          VALV_ASP <= 1'b0;
          ALARME   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rega_temporizador.sv
// Directed bench for rega_temporizador with small prescalers; expected values are worked out
// by hand from the edge count since reset release (tick on every 4th edge, S toggles every 2nd).
module tb_rega_temporizador;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SOLO_SECO = 1'b0;
  logic       NIVEL_BAIXO = 1'b0;
  logic       MODO_ASPER = 1'b0;
  logic       S;
  logic [3:0] ContA;
  logic [1:0] ContB;
  logic       VALV_GOT;
  logic       VALV_ASP;
  logic       ALARME;

  int errors = 0;
  int checks = 0;
  int k = 0;  // rising edges since reset release

  rega_temporizador #(
    .TICK_DIV (4),
    .SCAN_DIV (2),
    .DUR_GOTEJ(3),
    .DUR_ASPER(2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SOLO_SECO  (SOLO_SECO),
    .NIVEL_BAIXO(NIVEL_BAIXO),
    .MODO_ASPER (MODO_ASPER),
    .S          (S),
    .ContA      (ContA),
    .ContB      (ContB),
    .VALV_GOT   (VALV_GOT),
    .VALV_ASP   (VALV_ASP),
    .ALARME     (ALARME)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
    k += n;
  endtask

  task automatic expect_out(input string tag, input int a, input int b, input int vg,
                            input int va, input int al);
    check_eq({tag, ".ContA"}, int'(ContA), a);
    check_eq({tag, ".ContB"}, int'(ContB), b);
    check_eq({tag, ".VALV_GOT"}, int'(VALV_GOT), vg);
    check_eq({tag, ".VALV_ASP"}, int'(VALV_ASP), va);
    check_eq({tag, ".ALARME"}, int'(ALARME), al);
    check_eq({tag, ".S"}, int'(S), (k / 2) % 2);
  endtask

  initial begin
    // 1. Reset and scan strobe
    step(2);
    k = 0;
    expect_out("reset", 0, 0, 0, 0, 0);
    RST = 1'b0;
    step(1); expect_out("k1", 0, 0, 0, 0, 0);
    step(1); expect_out("k2_s_toggle", 0, 0, 0, 0, 0);
    step(2); expect_out("k4_idle_tick", 0, 0, 0, 0, 0);

    // 2. Drip cycle
    SOLO_SECO = 1'b1;
    MODO_ASPER = 1'b0;
    step(3); expect_out("k7_before_tick", 0, 0, 0, 0, 0);
    step(1); expect_out("drip_start", 3, 1, 1, 0, 0);
    step(4); expect_out("drip_2", 2, 1, 1, 0, 0);
    step(4); expect_out("drip_1", 1, 1, 1, 0, 0);
    step(3); expect_out("drip_1_hold", 1, 1, 1, 0, 0);
    MODO_ASPER = 1'b1;  // ignored mid-cycle
    step(1); expect_out("drip_end", 0, 0, 0, 0, 0);

    // 3. Sprinkler, restart on next tick, mode change ignored
    step(4); expect_out("asp_start", 2, 2, 0, 1, 0);
    MODO_ASPER = 1'b0;
    step(4); expect_out("asp_1", 1, 2, 0, 1, 0);
    step(4); expect_out("asp_end", 0, 0, 0, 0, 0);

    // 4. Alarm mid-cycle
    step(4); expect_out("drip2_start", 3, 1, 1, 0, 0);
    step(4); expect_out("drip2_2", 2, 1, 1, 0, 0);
    NIVEL_BAIXO = 1'b1;
    step(1); expect_out("alarm", 0, 3, 0, 0, 1);
    NIVEL_BAIXO = 1'b0;
    step(1); expect_out("alarm_clear", 0, 0, 0, 0, 0);
    step(2); expect_out("restart_after_alarm", 3, 1, 1, 0, 0);

    // 5. Alarm on the same edge as finishing tick, then as starting tick
    step(8); expect_out("drip3_1", 1, 1, 1, 0, 0);
    step(3);
    NIVEL_BAIXO = 1'b1;
    step(1); expect_out("alarm_vs_finish", 0, 3, 0, 0, 1);
    NIVEL_BAIXO = 1'b0;
    step(1); expect_out("idle_57", 0, 0, 0, 0, 0);
    step(2);
    NIVEL_BAIXO = 1'b1;
    step(1); expect_out("alarm_vs_start", 0, 3, 0, 0, 1);
    NIVEL_BAIXO = 1'b0;
    MODO_ASPER = 1'b1;
    step(1); expect_out("idle_61", 0, 0, 0, 0, 0);
    step(3); expect_out("asp2_start", 2, 2, 0, 1, 0);
    step(4); expect_out("asp2_1", 1, 2, 0, 1, 0);

    // 6. Reset mid-cycle; prescaler restarts
    RST = 1'b1;
    step(1);
    k = 0;
    expect_out("reset_mid", 0, 0, 0, 0, 0);
    RST = 1'b0;
    step(3); expect_out("post_rst_k3", 0, 0, 0, 0, 0);
    step(1); expect_out("post_rst_tick", 2, 2, 0, 1, 0);
    SOLO_SECO = 1'b0;
    step(4); expect_out("post_rst_1", 1, 2, 0, 1, 0);
    step(4); expect_out("post_rst_end", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
